imm_gen_pipe: RTL and testbench

//  Parametrised, pipelined RV immediate generator for the decode stage. Accepts one

---
 rtl/imm_gen_pipe.sv | 237 +++++++++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// imm_gen_pipe
//
// Pipelined RISC-V immediate generator for the decode stage. One instruction
// per cycle is accepted over a valid/ready handshake. The format is decoded
// from the opcode, and the sign-extended XLEN immediate, a format code and the
// caller's sideband tag are presented one cycle later. An output register plus
// a one-entry skid register keep the input ready registered while absorbing
// backpressure without losing or reordering entries.
//
// Parameters
//   XLEN   immediate/output width, 32 or 64
//   TAG_W  sideband tag width
//   CNT_W  statistics counter width (only meaningful with IMMGEN_STATS_EN)
//
// Optional feature macro: IMMGEN_STATS_EN
//   When defined, stat_total / stat_branch ports exist and count accepted
//   instructions (all / B-type), saturating, cleared synchronously by stat_clr.
//   When undefined, stat_clr is ignored and no counters are built.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     instruction present
//   in_ready     block can accept (registered)
//   in_instr     raw 32-bit instruction word
//   in_tag       sideband tag, passed through unchanged
//   out_valid    out_imm / out_type / out_tag valid
//   out_ready    consumer accepts
//   out_imm      sign-extended immediate
//   out_type     0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J
//   out_tag      tag belonging to out_imm
//   stat_clr     synchronous counter clear
//   stat_total   accepted instructions   (IMMGEN_STATS_EN only)
//   stat_branch  accepted B-type instrs  (IMMGEN_STATS_EN only)
// -----------------------------------------------------------------------------
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_type,
  output logic [TAG_W-1:0] out_tag,
  input  logic             stat_clr
`ifdef IMMGEN_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_total,
  output logic [CNT_W-1:0] stat_branch
`endif
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    imm_type_e        typ;
    logic [TAG_W-1:0] tag;
  } entry_t;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // ---------------------------------------------------------------------------
  // Decode. Every format is first assembled as a sign-extended 32-bit value;
  // the final signed width cast then extends bit 31 up to XLEN, which is what
  // the U format needs on RV64 and is a no-op on RV32.
  // ---------------------------------------------------------------------------
  logic [31:0] imm32;
  imm_type_e   dec_type;
  entry_t      dec;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    imm32    = '0;
    dec_type = IMM_NONE;
    unique case (in_instr[6:0])
      OP_IMM, OP_LOAD, OP_JALR: begin
        imm32    = {{20{in_instr[31]}}, in_instr[31:20]};
        dec_type = IMM_I;
      end
      OP_STORE: begin
        imm32    = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        dec_type = IMM_S;
      end
      OP_BRANCH: begin
        imm32    = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                    in_instr[30:25], in_instr[11:8], 1'b0};
        dec_type = IMM_B;
      end
      OP_LUI, OP_AUIPC: begin
        imm32    = {in_instr[31:12], 12'b0};
        dec_type = IMM_U;
      end
      OP_JAL: begin
        imm32    = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                    in_instr[20], in_instr[30:21], 1'b0};
        dec_type = IMM_J;
      end
      default: begin
        // Unknown opcodes still flow through the pipe as NONE with imm 0.
        imm32    = '0;
        dec_type = IMM_NONE;
      end
    endcase
  end

  always_comb begin
    dec.imm = XLEN'($signed(imm32));
    dec.typ = dec_type;
    dec.tag = in_tag;
  end

  // ---------------------------------------------------------------------------
  // Output register O and skid register K.
  // in_ready is just !k_valid, so it comes straight from a flop. While K is
  // full the input is closed; the next free output slot drains K into O.
  // ---------------------------------------------------------------------------
  logic   o_valid;
  entry_t o_data;
  logic   k_valid;
  entry_t k_data;

  logic accept;
  logic o_free;    // O is empty or is being consumed this cycle
  logic k_to_o;
  logic dec_to_o;
  logic dec_to_k;

  always_comb begin
    accept   = in_valid && !k_valid;
    o_free   = !o_valid || out_ready;
    k_to_o   = o_free && k_valid;
    dec_to_o = o_free && !k_valid && accept;
    dec_to_k = !o_free && accept;
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      k_valid <= 1'b0;
    end else begin
      if (o_free) begin
        o_valid <= k_valid || accept;
      end
      if (k_to_o) begin
        o_data <= k_data;
      end else if (dec_to_o) begin
        o_data <= dec;
      end

      if (k_to_o) begin
        k_valid <= 1'b0;
      end else if (dec_to_k) begin
        k_valid <= 1'b1;
      end
    end
  end

  // NOTE: the skid payload has no reset on purpose; it is only ever read when
  // k_valid is set, and k_valid itself is reset.
  always_ff @(posedge clk) begin
    if (dec_to_k) begin
      k_data <= dec;
    end
  end

  assign in_ready  = !k_valid;
  assign out_valid = o_valid;
  assign out_imm   = o_data.imm;
  assign out_type  = o_data.typ;
  assign out_tag   = o_data.tag;

  // ---------------------------------------------------------------------------
  // Optional statistics. Clear has priority over a same-cycle accept.
  // ---------------------------------------------------------------------------
`ifdef IMMGEN_STATS_EN
  logic [CNT_W-1:0] cnt_total;
  logic [CNT_W-1:0] cnt_branch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_total  <= '0;
      cnt_branch <= '0;
    end else if (stat_clr) begin
      cnt_total  <= '0;
      cnt_branch <= '0;
    end else if (accept) begin
      if (!(&cnt_total)) begin
        cnt_total <= cnt_total + CNT_W'(1);
      end
      if (dec_type == IMM_B && !(&cnt_branch)) begin
        cnt_branch <= cnt_branch + CNT_W'(1);
      end
    end
  end

  assign stat_total  = cnt_total;
  assign stat_branch = cnt_branch;
`else
  // Counters are not built; the clear input and counter width are unused.
  logic              unused_stat_clr;
  localparam int     unused_cnt_w = CNT_W;
  assign unused_stat_clr = stat_clr;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_imm_gen_pipe
//
// Directed bench for imm_gen_pipe. Two instances share all inputs: one built
// with XLEN=32 and one with XLEN=64. With IMMGEN_STATS_EN defined both use
// CNT_W=2 so counter saturation is reachable in a few accepts.
// -----------------------------------------------------------------------------
module tb_imm_gen_pipe;

  localparam int TAG_W = 5;
  localparam int CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_ready;
  logic             stat_clr;

  logic             in_ready32, out_valid32;
  logic [31:0]      out_imm32;
  logic [2:0]       out_type32;
  logic [TAG_W-1:0] out_tag32;

  logic             in_ready64, out_valid64;
  logic [63:0]      out_imm64;
  logic [2:0]       out_type64;
  logic [TAG_W-1:0] out_tag64;

`ifdef IMMGEN_STATS_EN
  logic [CNT_W-1:0] stat_total32, stat_branch32;
  logic [CNT_W-1:0] stat_total64, stat_branch64;
`endif

  int total = 0;
  int bad   = 0;

  imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut32 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready32),
    .in_instr   (in_instr),
    .in_tag     (in_tag),
    .out_valid  (out_valid32),
    .out_ready  (out_ready),
    .out_imm    (out_imm32),
    .out_type   (out_type32),
    .out_tag    (out_tag32),
    .stat_clr   (stat_clr)
`ifdef IMMGEN_STATS_EN
    ,
    .stat_total (stat_total32),
    .stat_branch(stat_branch32)
`endif
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut64 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready64),
    .in_instr   (in_instr),
    .in_tag     (in_tag),
    .out_valid  (out_valid64),
    .out_ready  (out_ready),
    .out_imm    (out_imm64),
    .out_type   (out_type64),
    .out_tag    (out_tag64),
    .stat_clr   (stat_clr)
`ifdef IMMGEN_STATS_EN
    ,
    .stat_total (stat_total64),
    .stat_branch(stat_branch64)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] addi(input int k);
    return {12'(k), 20'h00093};
  endfunction

  // Decode vectors: instruction, expected XLEN=64 immediate (low half is the
  // XLEN=32 result), expected format code.
  localparam int NV = 15;
  logic [31:0] v_instr [NV] = '{
    32'hFFF00093, 32'hFE000EE3, 32'h123450B7, 32'h0010006F, 32'h00000033,
    32'hFE112E23, 32'h800000B7, 32'h00001017, 32'h7FF02083, 32'h800080E7,
    32'h00000463, 32'hFFFFF06F, 32'hFFFFFFFF, 32'h00112623, 32'h00000FE3};
  logic [63:0] v_imm [NV] = '{
    64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'h0000000012345000,
    64'h0000000000000800, 64'h0000000000000000, 64'hFFFFFFFFFFFFFFFC,
    64'hFFFFFFFF80000000, 64'h0000000000001000, 64'h00000000000007FF,
    64'hFFFFFFFFFFFFF800, 64'h0000000000000008, 64'hFFFFFFFFFFFFFFFE,
    64'h0000000000000000, 64'h000000000000000C, 64'h000000000000081E};
  logic [2:0]  v_type [NV] = '{
    3'd1, 3'd3, 3'd4, 3'd5, 3'd0, 3'd2, 3'd4, 3'd4,
    3'd1, 3'd1, 3'd3, 3'd5, 3'd0, 3'd2, 3'd3};

  task automatic test_reset();
    tick();
    total++; if (out_valid32 !== 1'b0) begin bad++; $display("FAIL reset out_valid: got %b want 0", out_valid32); end
    total++; if (in_ready32 !== 1'b1) begin bad++; $display("FAIL reset in_ready: got %b want 1", in_ready32); end
    total++; if (out_imm64 !== 64'h0) begin bad++; $display("FAIL reset out_imm: got %h want 0", out_imm64); end
    total++; if (out_type32 !== 3'd0) begin bad++; $display("FAIL reset out_type: got %0d want 0", out_type32); end
    total++; if (out_tag32 !== '0) begin bad++; $display("FAIL reset out_tag: got %0d want 0", out_tag32); end
`ifdef IMMGEN_STATS_EN
    total++; if (stat_total32 !== '0 || stat_branch32 !== '0) begin
      bad++; $display("FAIL reset stats: got %0d/%0d want 0/0", stat_total32, stat_branch32);
    end
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_decode();
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1;
      in_instr = v_instr[i];
      in_tag   = TAG_W'(i);
      tick();
      total++; if (out_valid32 !== 1'b1 || out_valid64 !== 1'b1) begin
        bad++; $display("FAIL decode[%0d] valid: got %b/%b want 1/1", i, out_valid32, out_valid64);
      end
      total++; if (out_imm32 !== v_imm[i][31:0]) begin
        bad++; $display("FAIL decode[%0d] imm32 (%h): got %h want %h", i, v_instr[i], out_imm32, v_imm[i][31:0]);
      end
      total++; if (out_imm64 !== v_imm[i]) begin
        bad++; $display("FAIL decode[%0d] imm64 (%h): got %h want %h", i, v_instr[i], out_imm64, v_imm[i]);
      end
      total++; if (out_type32 !== v_type[i] || out_type64 !== v_type[i]) begin
        bad++; $display("FAIL decode[%0d] type: got %0d/%0d want %0d", i, out_type32, out_type64, v_type[i]);
      end
      total++; if (out_tag32 !== TAG_W'(i)) begin
        bad++; $display("FAIL decode[%0d] tag: got %0d want %0d", i, out_tag32, i);
      end
    end
    in_valid = 1'b0;
    tick();
    total++; if (out_valid32 !== 1'b0) begin bad++; $display("FAIL decode drain: out_valid got %b want 0", out_valid32); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1; in_instr = addi(1); in_tag = 5'd1;
    tick();  // accept 1 into O
    total++; if (out_valid32 !== 1'b1 || out_tag32 !== 5'd1 || in_ready32 !== 1'b1) begin
      bad++; $display("FAIL bp cycle1: valid=%b tag=%0d in_ready=%b want 1/1/1", out_valid32, out_tag32, in_ready32);
    end
    in_instr = addi(2); in_tag = 5'd2;
    tick();  // accept 2 into K
    total++; if (out_tag32 !== 5'd1 || out_imm32 !== 32'd1 || in_ready32 !== 1'b0) begin
      bad++; $display("FAIL bp cycle2: tag=%0d imm=%h in_ready=%b want 1/1/0", out_tag32, out_imm32, in_ready32);
    end
    in_instr = addi(3); in_tag = 5'd3;
    tick();  // stalled, nothing accepted
    total++; if (out_valid32 !== 1'b1 || out_tag32 !== 5'd1 || out_imm32 !== 32'd1 || in_ready32 !== 1'b0) begin
      bad++; $display("FAIL bp stall: valid=%b tag=%0d imm=%h in_ready=%b want 1/1/1/0", out_valid32, out_tag32, out_imm32, in_ready32);
    end
    out_ready = 1'b1;
    tick();  // 1 leaves, K drains into O
    total++; if (out_valid32 !== 1'b1 || out_tag32 !== 5'd2 || out_imm32 !== 32'd2 || in_ready32 !== 1'b1) begin
      bad++; $display("FAIL bp drain: valid=%b tag=%0d imm=%h in_ready=%b want 1/2/2/1", out_valid32, out_tag32, out_imm32, in_ready32);
    end
    tick();  // 3 accepted
    total++; if (out_tag32 !== 5'd3 || out_imm32 !== 32'd3) begin
      bad++; $display("FAIL bp tag3: tag=%0d imm=%h want 3/3", out_tag32, out_imm32);
    end
    in_instr = addi(4); in_tag = 5'd4;
    tick();
    total++; if (out_tag32 !== 5'd4 || out_imm32 !== 32'd4) begin
      bad++; $display("FAIL bp tag4: tag=%0d imm=%h want 4/4", out_tag32, out_imm32);
    end
    in_valid = 1'b0;
    tick();
    total++; if (out_valid32 !== 1'b0) begin bad++; $display("FAIL bp empty: out_valid got %b want 0", out_valid32); end
  endtask

  // Streams tags 1..8 against an irregular out_ready pattern and checks that
  // every transfer carries the next tag in order, with no loss or duplicate.
  task automatic test_back_to_back();
    logic [15:0]      rdy_pat = 16'b1011_0010_0111_0001;
    int               next_in  = 1;
    int               next_out = 1;
    logic             acc, xfer;
    logic [TAG_W-1:0] xtag;
    logic [31:0]      ximm;
    in_valid  = 1'b1;
    in_instr  = addi(1);
    in_tag    = TAG_W'(1);
    out_ready = rdy_pat[0];
    for (int cyc = 0; cyc < 100 && next_out <= 8; cyc++) begin
      acc  = in_valid && in_ready32;
      xfer = out_valid32 && out_ready;
      xtag = out_tag32;
      ximm = out_imm32;
      tick();
      if (xfer) begin
        total++; if (xtag !== TAG_W'(next_out) || ximm !== 32'(next_out)) begin
          bad++; $display("FAIL b2b order: got tag %0d imm %h want tag %0d imm %h", xtag, ximm, next_out, 32'(next_out));
        end
        next_out++;
      end
      if (acc) next_in++;
      in_valid  = (next_in <= 8);
      in_instr  = addi(next_in);
      in_tag    = TAG_W'(next_in);
      out_ready = rdy_pat[(cyc + 1) % 16];
    end
    total++; if (next_out != 9) begin
      bad++; $display("FAIL b2b count: got %0d transfers want 8 within budget", next_out - 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    total++; if (out_valid32 !== 1'b0) begin bad++; $display("FAIL b2b extra entry: out_valid got %b want 0", out_valid32); end
  endtask

`ifdef IMMGEN_STATS_EN
  task automatic test_stats();
    in_valid = 1'b0; out_ready = 1'b1; stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    total++; if (stat_total32 !== 2'd0 || stat_branch32 !== 2'd0) begin
      bad++; $display("FAIL stats clear: got %0d/%0d want 0/0", stat_total32, stat_branch32);
    end
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = 5'd1;
    tick();
    in_instr = 32'hFE000EE3;
    tick();
    in_valid = 1'b0;
    total++; if (stat_total32 !== 2'd2 || stat_branch32 !== 2'd1) begin
      bad++; $display("FAIL stats mix: got %0d/%0d want 2/1", stat_total32, stat_branch32);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    in_valid = 1'b0;
    total++; if (stat_total32 !== 2'd3 || stat_branch32 !== 2'd3 || stat_branch64 !== 2'd3) begin
      bad++; $display("FAIL stats saturate: got %0d/%0d want 3/3", stat_total32, stat_branch32);
    end
    in_valid = 1'b1; stat_clr = 1'b1;
    tick();
    in_valid = 1'b0; stat_clr = 1'b0;
    total++; if (stat_total32 !== 2'd0 || stat_branch32 !== 2'd0) begin
      bad++; $display("FAIL stats clear wins: got %0d/%0d want 0/0", stat_total32, stat_branch32);
    end
    tick();
  endtask
`endif

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1; in_instr = 32'hFFF00093; in_tag = 5'd7;
    tick();
    in_instr = 32'h800000B7; in_tag = 5'd8;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid64 !== 1'b1 || in_ready64 !== 1'b0 || out_imm64 !== 64'hFFFFFFFFFFFFFFFF) begin
      bad++; $display("FAIL rmid full: valid=%b in_ready=%b imm=%h want 1/0/ffffffffffffffff", out_valid64, in_ready64, out_imm64);
    end
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid64 !== 1'b0 || in_ready64 !== 1'b1 || out_valid32 !== 1'b0 || in_ready32 !== 1'b1) begin
      bad++; $display("FAIL rmid async: valid=%b in_ready=%b want 0/1", out_valid64, in_ready64);
    end
    total++; if (out_imm64 !== 64'h0 || out_tag64 !== '0 || out_type64 !== 3'd0) begin
      bad++; $display("FAIL rmid outputs: imm=%h tag=%0d type=%0d want 0/0/0", out_imm64, out_tag64, out_type64);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    total++; if (out_valid64 !== 1'b0 || out_valid32 !== 1'b0) begin
      bad++; $display("FAIL rmid dropped: out_valid got %b/%b want 0/0", out_valid32, out_valid64);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    stat_clr  = 1'b0;
    test_reset();
    test_decode();
    test_backpressure();
    test_back_to_back();
`ifdef IMMGEN_STATS_EN
    test_stats();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
